// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC and issues one fetch at a time to instruction memory.
// Buffers returned words with their PC in a small FIFO that feeds decode.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
    input  logic                  imem_rsp_err_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [INST_WIDTH-1:0] instr_idu_o,
    output logic [ADDR_WIDTH-1:0] pc_idu_o,
    output logic                  fetch_err_idu_o,
    output logic                  valid_idu_o,
    input  logic                  ready_idu_i
);

    localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH + 1;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ENTRY_W-1:0]    r_mem [BUF_DEPTH];

    logic                  w_full;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_push;
    logic                  w_out_valid;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic [ENTRY_W-1:0]    w_head;

    assign w_full        = (r_count == CNT_W'(BUF_DEPTH));
    assign w_req_valid   = rst_n && (r_state == S_REQ) && !w_full && !redirect_valid_i;
    assign w_req_fire    = w_req_valid && imem_req_ready_i;
    assign w_push        = (r_state == S_WAIT) && imem_rsp_valid_i && !redirect_valid_i;
    assign w_out_valid   = rst_n && (r_count != '0);
    assign w_pop         = w_out_valid && ready_idu_i && !redirect_valid_i;
    assign w_redirect_pc = redirect_pc_i & ~ADDR_WIDTH'(3);
    assign w_head        = r_mem[r_rd_ptr];

    // A response that coincides with a redirect is always the one we were waiting
    // for, so DROP is only needed when the old response is still to come.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ:   if (w_req_fire) w_state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid_i)      w_state_next = S_REQ;
                else if (redirect_valid_i) w_state_next = S_DROP;
            end
            S_DROP:  if (imem_rsp_valid_i) w_state_next = S_REQ;
            default: w_state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_req_fire) r_req_pc <= r_fetch_pc;

            if (redirect_valid_i)  r_fetch_pc <= w_redirect_pc;
            else if (w_req_fire)   r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);

            if (redirect_valid_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage is not reset; entries are only observed once count marks them valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_push)
            r_mem[r_wr_ptr] <= {r_req_pc, imem_rsp_data_i, imem_rsp_err_i};
    end

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = rst_n ? r_fetch_pc : '0;
    assign valid_idu_o      = w_out_valid;
    assign pc_idu_o         = w_out_valid ? w_head[ENTRY_W-1 -: ADDR_WIDTH] : '0;
    assign instr_idu_o      = w_out_valid ? w_head[INST_WIDTH:1] : '0;
    assign fetch_err_idu_o  = w_out_valid ? w_head[0] : 1'b0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: the bench plays instruction memory and execute,
// keeps an abstract model of the PC stream and buffered words, and scoreboards decode output.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_idu_o;
    logic [31:0] pc_idu_o;
    logic        fetch_err_idu_o;
    logic        valid_idu_o;
    logic        ready_idu_i;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_idu_o      (instr_idu_o),
        .pc_idu_o         (pc_idu_o),
        .fetch_err_idu_o  (fetch_err_idu_o),
        .valid_idu_o      (valid_idu_o),
        .ready_idu_i      (ready_idu_i)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } ent_t;

    ent_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Stimulus knobs
    int          p_req_rdy = 100;
    int          p_idu_rdy = 100;
    int          p_redir   = 0;
    int          min_dly   = 0;
    int          max_dly   = 0;
    int          force_mode = 0;
    logic [31:0] force_tgt;
    logic [31:0] err_pc = 32'h8000_0004;
    bit          run = 1'b0;

    // Abstract model: next sequential PC, one in-flight fetch, expected decode queue
    logic [31:0] m_pc = 32'h8000_0000;
    bit          m_infl = 1'b0;
    bit          m_live = 1'b0;
    logic [31:0] m_ipc;
    logic [31:0] m_idata;
    bit          m_ierr;
    int          m_dly;
    bit          exp_req_valid = 1'b0;
    logic [31:0] exp_req_addr  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(1) == 0) return 32'h8000_0000 | $urandom_range(0, 32'hfff);
        return $urandom;
    endfunction

    // Driver: memory, execute and decode stand-ins; updates the model at each edge
    initial begin
        bit          d_redir, d_rsp, d_acc, d_rdy;
        logic [31:0] d_tgt;
        forever begin
            @(negedge clk);
            if (run) begin
                d_rsp   = m_infl && (m_dly == 0);
                d_redir = ($urandom_range(99) < p_redir);
                d_tgt   = rand_target();
                d_rdy   = ($urandom_range(99) < p_idu_rdy);
                if (force_mode == 1 && m_infl && m_live && !d_rsp) begin
                    d_redir = 1'b1; d_tgt = force_tgt; force_mode = 0;
                end else if (force_mode == 2 && d_rsp && m_live && expq.size() != 0) begin
                    d_redir = 1'b1; d_tgt = force_tgt; d_rdy = 1'b1; force_mode = 0;
                end else if (force_mode == 3) begin
                    d_redir = 1'b1; d_tgt = force_tgt; force_mode = 0;
                end
                exp_req_valid    = !m_infl && (expq.size() < 2) && !d_redir;
                exp_req_addr     = m_pc;
                imem_req_ready_i = ($urandom_range(99) < p_req_rdy);
                d_acc            = exp_req_valid && imem_req_ready_i;
                redirect_valid_i = d_redir;
                redirect_pc_i    = d_tgt;
                imem_rsp_valid_i = d_rsp;
                imem_rsp_data_i  = d_rsp ? m_idata : $urandom;
                imem_rsp_err_i   = d_rsp ? m_ierr : 1'($urandom_range(1));
                ready_idu_i      = d_rdy;

                @(posedge clk);
                if (d_rsp) begin
                    if (m_live && !d_redir) begin
                        ent_t e;
                        e.pc = m_ipc; e.data = m_idata; e.err = m_ierr;
                        expq.push_back(e);
                    end
                    m_infl = 1'b0;
                end else if (m_infl && m_dly > 0) begin
                    m_dly--;
                end
                if (d_redir) begin
                    expq.delete();
                    m_pc   = d_tgt & ~32'h3;
                    m_live = 1'b0;
                end else if (d_acc) begin
                    m_infl  = 1'b1;
                    m_live  = 1'b1;
                    m_ipc   = m_pc;
                    m_idata = $urandom;
                    m_ierr  = (m_pc == err_pc) || ($urandom_range(7) == 0);
                    m_dly   = $urandom_range(max_dly, min_dly);
                    m_pc    = m_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: compares request channel each cycle and pops the scoreboard on decode handshakes
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (run) begin
                check("req_valid", 64'(imem_req_valid_o), 64'(exp_req_valid));
                if (imem_req_valid_o && exp_req_valid)
                    check("req_addr", 64'(imem_req_addr_o), 64'(exp_req_addr));
                check("out_valid", 64'(valid_idu_o), 64'(expq.size() != 0));
                if (valid_idu_o && ready_idu_i && !redirect_valid_i) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out: got pc %h with nothing expected at %0t", pc_idu_o, $time);
                    end else begin
                        e = expq.pop_front();
                        check("out_pc",    64'(pc_idu_o),        64'(e.pc));
                        check("out_instr", 64'(instr_idu_o),     64'(e.data));
                        check("out_err",   64'(fetch_err_idu_o), 64'(e.err));
                        $display("pop pc=%h instr=%h err=%0d", pc_idu_o, instr_idu_o, fetch_err_idu_o);
                    end
                end
            end
        end
    end

    task automatic wait_force(input string name);
        for (int i = 0; i < 200 && force_mode != 0; i++) @(negedge clk);
        n_checks++;
        if (force_mode == 0) n_pass++;
        else begin
            $display("FAIL %s: forced redirect not applied, got pending expected applied", name);
            force_mode = 0;
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        ready_idu_i      = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("rst_out_valid", 64'(valid_idu_o),      64'd0);
        check("rst_instr",     64'(instr_idu_o),      64'd0);
        check("rst_pc",        64'(pc_idu_o),         64'd0);
        check("rst_err",       64'(fetch_err_idu_o),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b1;

        // Streaming with instant memory and decode
        repeat (20) @(negedge clk);
        // Decode stall fills the buffer, then drains
        p_idu_rdy = 0;
        repeat (10) @(negedge clk);
        p_idu_rdy = 100;
        repeat (10) @(negedge clk);
        // Redirect while waiting on a slow response
        min_dly = 3; max_dly = 3;
        force_tgt = 32'h8000_0103; force_mode = 1;
        wait_force("redirect_wait");
        repeat (10) @(negedge clk);
        min_dly = 0; max_dly = 0;
        // Redirect coinciding with a response and a pop
        p_idu_rdy = 0;
        force_tgt = 32'h8000_0200; force_mode = 2;
        wait_force("redirect_rsp_pop");
        p_idu_rdy = 100;
        repeat (10) @(negedge clk);
        // PC wrap at top of address space, with memory backpressure
        force_tgt = 32'hFFFF_FFFC; force_mode = 3;
        wait_force("redirect_wrap");
        p_req_rdy = 30;
        repeat (20) @(negedge clk);
        // Random traffic
        p_req_rdy = 70; p_idu_rdy = 60; p_redir = 5; max_dly = 3;
        repeat (3000) @(negedge clk);
        p_redir = 0;
        repeat (20) @(negedge clk);
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
